// File: rtl/sched_pkg.sv
// -----------------------------------------------------------------------------
// sched_pkg
// Shared types and sizing helpers for the systolic-array scheduler.
//   state_e   : scheduler FSM states (IDLE, LOAD, COMPUTE, DONE)
//   cnt_width : width of a counter whose largest value is max_val
//               ($clog2(max_val+1), never less than one bit)
// -----------------------------------------------------------------------------
package sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Counts STEP_CYCLES enabled cycles while run is high and flags the last cycle
// of each step with step_tick.
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   enable    in   global advance; low freezes the count
//   clear     in   restart the count at zero (wavefront entry)
//   run       in   count while high, otherwise the count is parked at zero
//   step_tick out  high during the final enabled cycle of a step
// -----------------------------------------------------------------------------
module step_timer
  import sched_pkg::*;
#(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic run,
  output logic step_tick
);

  localparam int TW = cnt_width(STEP_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(STEP_CYCLES - 1);

  logic [TW-1:0] cnt_r;

  // cycle-within-step counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (enable) begin
      if (clear) begin
        cnt_r <= '0;
      end else if (run) begin
        if (cnt_r == T_LAST) begin
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + TW'(1'b1);
        end
      end else begin
        cnt_r <= '0;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // tick is deliberately independent of clear so it never loops back through
  // the scheduler's next-state logic
  assign step_tick = enable && run && (cnt_r == T_LAST);

endmodule

// File: rtl/array_scheduler.sv
// -----------------------------------------------------------------------------
// array_scheduler
// Sequences one weight-load + diagonal-wavefront compute pass over a
// ROWS x COLS processing-element array.
// Ports:
//   clk           in   clock
//   reset         in   synchronous active-high reset (beats enable and start)
//   enable        in   global advance; low freezes state and outputs
//   start         in   request a pass (accepted only in IDLE)
//   reuse_weights in   skip the LOAD phase (only with SCHED_REUSE_WEIGHTS_EN)
//   load_weight   out  one-hot per-row weight-load strobe
//   enable_mult   out  per-row multiply enable
//   busy          out  high during LOAD and COMPUTE
//   done          out  one-cycle completion pulse
// Build option: define SCHED_REUSE_WEIGHTS_EN to add the reuse_weights port.
// All outputs are registered decodes of the current state, so they trail the
// state register by one enabled cycle.
// -----------------------------------------------------------------------------
module array_scheduler
  import sched_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int STEP_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            start,
`ifdef SCHED_REUSE_WEIGHTS_EN
  input  logic            reuse_weights,
`endif
  output logic [ROWS-1:0] load_weight,
  output logic [ROWS-1:0] enable_mult,
  output logic            busy,
  output logic            done
);

  localparam int ROW_W  = cnt_width(ROWS - 1);
  localparam int STEP_W = cnt_width(ROWS + COLS - 2);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ROWS + COLS - 2);

  state_e              state_r, state_n;
  logic [ROW_W-1:0]    row_r, row_n;
  logic [STEP_W-1:0]   step_r, step_n;
  logic                reuse_s;
  logic                step_tick_s;
  logic                enter_compute_s;
  logic [ROWS-1:0]     load_weight_s, enable_mult_s;
  logic                busy_s, done_s;
  logic [ROWS-1:0]     load_weight_r, enable_mult_r;
  logic                busy_r, done_r;

`ifdef SCHED_REUSE_WEIGHTS_EN
  assign reuse_s = reuse_weights;
`else
  assign reuse_s = 1'b0;
`endif

  // COMPUTE is entered either straight from IDLE (weights reused) or after the
  // last row strobe; derived from current state only to keep it loop-free
  assign enter_compute_s = ((state_r == IDLE) && start && reuse_s) ||
                           ((state_r == LOAD) && (row_r == ROW_LAST));

  step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .clear     (enter_compute_s),
    .run       (state_r == COMPUTE),
    .step_tick (step_tick_s)
  );

  // next-state and counter logic
  always_comb begin
    state_n = state_r;
    row_n   = row_r;
    step_n  = step_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          row_n  = '0;
          step_n = '0;
          if (reuse_s) begin
            state_n = COMPUTE;
          end else begin
            state_n = LOAD;
          end
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        if (row_r == ROW_LAST) begin
          state_n = COMPUTE;
          row_n   = '0;
          step_n  = '0;
        end else begin
          row_n = row_r + ROW_W'(1'b1);
        end
      end
      COMPUTE: begin
        if (step_tick_s) begin
          if (step_r == STEP_LAST) begin
            state_n = DONE;
            step_n  = '0;
          end else begin
            step_n = step_r + STEP_W'(1'b1);
          end
        end else begin
          state_n = COMPUTE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        row_n   = '0;
        step_n  = '0;
      end
    endcase
  end

  // output decode of the current state, captured into output registers
  always_comb begin
    load_weight_s = '0;
    enable_mult_s = '0;
    busy_s        = 1'b0;
    done_s        = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
      end
      LOAD: begin
        load_weight_s[row_r] = 1'b1;
        busy_s               = 1'b1;
      end
      COMPUTE: begin
        busy_s = 1'b1;
        // row i is active while the wavefront covers it: i <= s < i+COLS
        for (int i = 0; i < ROWS; i++) begin
          enable_mult_s[i] = (int'(step_r) >= i) && (int'(step_r) < i + COLS);
        end
      end
      DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // state, counters and registered outputs; enable low holds everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      row_r         <= '0;
      step_r        <= '0;
      load_weight_r <= '0;
      enable_mult_r <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else if (enable) begin
      state_r       <= state_n;
      row_r         <= row_n;
      step_r        <= step_n;
      load_weight_r <= load_weight_s;
      enable_mult_r <= enable_mult_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
    end else begin
      state_r       <= state_r;
      row_r         <= row_r;
      step_r        <= step_r;
      load_weight_r <= load_weight_r;
      enable_mult_r <= enable_mult_r;
      busy_r        <= busy_r;
      done_r        <= done_r;
    end
  end

  assign load_weight = load_weight_r;
  assign enable_mult = enable_mult_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_array_scheduler.sv
// -----------------------------------------------------------------------------
// tb_array_scheduler
// Directed bench: dut_a is 2x2 with 4-cycle steps (table-driven passes, freeze,
// start held through DONE, mid-run reset); dut_b is 3x2 with 1-cycle steps.
// -----------------------------------------------------------------------------
module tb_array_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_a, st_a, en_b, st_b;
  logic [1:0] lw_a, em_a;
  logic       busy_a, done_a;
  logic [2:0] lw_b, em_b;
  logic       busy_b, done_b;
`ifdef SCHED_REUSE_WEIGHTS_EN
  logic       reuse_a, reuse_b;
`endif

  always #5 clk = ~clk;

  array_scheduler #(.ROWS(2), .COLS(2), .STEP_CYCLES(4)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .enable      (en_a),
    .start       (st_a),
`ifdef SCHED_REUSE_WEIGHTS_EN
    .reuse_weights (reuse_a),
`endif
    .load_weight (lw_a),
    .enable_mult (em_a),
    .busy        (busy_a),
    .done        (done_a)
  );

  array_scheduler #(.ROWS(3), .COLS(2), .STEP_CYCLES(1)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .enable      (en_b),
    .start       (st_b),
`ifdef SCHED_REUSE_WEIGHTS_EN
    .reuse_weights (reuse_b),
`endif
    .load_weight (lw_b),
    .enable_mult (em_b),
    .busy        (busy_b),
    .done        (done_b)
  );

  typedef struct {
    logic       en;
    logic       st;
    logic [1:0] lw;
    logic [1:0] em;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input logic st, input logic [1:0] lw,
                     input logic [1:0] em, input logic busy, input logic done);
    vec_t v;
    v.en = en; v.st = st; v.lw = lw; v.em = em; v.busy = busy; v.done = done;
    vecs.push_back(v);
  endtask

  // One 2x2/4-cycle pass: vector k is applied before edge k and the outputs
  // are checked after it. Optional: start held from k=5 through DONE, a
  // 3-cycle freeze right after k=7 (step 1), and a frozen cycle after done.
  task automatic fill_pass(input bit hold, input bit freeze, input bit stretch);
    logic [1:0] lw, em;
    logic b, d, st;
    for (int k = 0; k < 16; k++) begin
      lw = 2'b00; em = 2'b00;
      if (k == 1) lw = 2'b01;
      else if (k == 2) lw = 2'b10;
      if (k >= 3 && k <= 6) em = 2'b01;
      else if (k >= 7 && k <= 10) em = 2'b11;
      else if (k >= 11 && k <= 14) em = 2'b10;
      b  = (k >= 1 && k <= 14);
      d  = (k == 15);
      st = (k == 0) || (hold && k >= 5);
      add(1'b1, st, lw, em, b, d);
      if (freeze && k == 7) begin
        for (int f = 0; f < 3; f++) add(1'b0, 1'b0, lw, em, b, d);
      end
    end
    if (stretch) add(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
  endtask

  logic [2:0] exp_lw_b [0:8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b000,
                                 3'b000, 3'b000, 3'b000, 3'b000};
  logic [2:0] exp_em_b [0:8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001,
                                 3'b011, 3'b110, 3'b100, 3'b000};

  initial begin
    int lat;
    reset = 1'b1; en_a = 1'b1; st_a = 1'b1; en_b = 1'b1; st_b = 1'b0;
`ifdef SCHED_REUSE_WEIGHTS_EN
    reuse_a = 1'b0; reuse_b = 1'b0;
`endif
    // reset beats start
    tick(); tick();
    chk("reset_lw_a",   32'(lw_a),   32'd0);
    chk("reset_em_a",   32'(em_a),   32'd0);
    chk("reset_busy_a", 32'(busy_a), 32'd0);
    chk("reset_done_a", 32'(done_a), 32'd0);
    chk("reset_lw_b",   32'(lw_b),   32'd0);
    st_a = 1'b0; reset = 1'b0;
    tick();
    chk("idle_after_reset_busy_a", 32'(busy_a), 32'd0);

    // table: plain pass, freeze pass, held-start pass, immediate new pass
    fill_pass(1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    fill_pass(1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    fill_pass(1'b1, 1'b0, 1'b0);
    fill_pass(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      en_a = vecs[i].en;
      st_a = vecs[i].st;
      tick();
      chk($sformatf("vec%0d_load_weight", i), 32'(lw_a),   32'(vecs[i].lw));
      chk($sformatf("vec%0d_enable_mult", i), 32'(em_a),   32'(vecs[i].em));
      chk($sformatf("vec%0d_busy", i),        32'(busy_a), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_done", i),        32'(done_a), 32'(vecs[i].done));
    end
    en_a = 1'b1; st_a = 1'b0;

    // reset during step 1 of a pass, then a normal pass
    st_a = 1'b1; tick(); st_a = 1'b0;
    for (int c = 1; c <= 7; c++) tick();
    chk("pre_reset_em_a", 32'(em_a), 32'd3);
    reset = 1'b1; tick();
    chk("midrun_reset_lw",   32'(lw_a),   32'd0);
    chk("midrun_reset_em",   32'(em_a),   32'd0);
    chk("midrun_reset_busy", 32'(busy_a), 32'd0);
    chk("midrun_reset_done", 32'(done_a), 32'd0);
    reset = 1'b0; tick();
    chk("post_reset_idle_em", 32'(em_a), 32'd0);
    st_a = 1'b1; tick(); st_a = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) chk("post_reset_first_strobe", 32'(lw_a), 32'd1);
      if (done_a === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk("post_reset_latency", 32'(lat), 32'd15);
    tick();

    // 3x2 array, single-cycle steps
    st_b = 1'b1; tick(); st_b = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("b_cyc%0d_load_weight", c), 32'(lw_b),   32'(exp_lw_b[c]));
      chk($sformatf("b_cyc%0d_enable_mult", c), 32'(em_b),   32'(exp_em_b[c]));
      chk($sformatf("b_cyc%0d_done", c),        32'(done_b), 32'(c == 8));
      chk($sformatf("b_cyc%0d_busy", c),        32'(busy_b), 32'(c <= 7));
    end

`ifdef SCHED_REUSE_WEIGHTS_EN
    // weights reused: no LOAD phase, done two cycles earlier
    tick();
    reuse_a = 1'b1; st_a = 1'b1; tick(); reuse_a = 1'b0; st_a = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      logic [1:0] e;
      tick();
      e = 2'b00;
      if (c <= 4) e = 2'b01;
      else if (c <= 8) e = 2'b11;
      else if (c <= 12) e = 2'b10;
      chk($sformatf("reuse_cyc%0d_load_weight", c), 32'(lw_a),   32'd0);
      chk($sformatf("reuse_cyc%0d_enable_mult", c), 32'(em_a),   32'(e));
      chk($sformatf("reuse_cyc%0d_done", c),        32'(done_a), 32'(c == 13));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/array_scheduler.md
ARRAY_SCHEDULER -- requirements
Module: array_scheduler

Interface
REQ-001 Parameter ROWS, 4, number of PE rows; SHALL be >= 1.
REQ-002 Parameter COLS, 4, number of PE columns; SHALL be >= 1.
REQ-003 Parameter STEP_CYCLES, 4, clock cycles per wavefront step; SHALL be >= 1.
REQ-004 clk  input  1  clock; all state SHALL change only on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  global advance; low SHALL freeze all state, counters and outputs.
REQ-007 start  input  1  request one load+compute pass; sampled only in IDLE with enable high.
REQ-008 load_weight  output  ROWS  one-hot weight-load strobe, bit i = row i.
REQ-009 enable_mult  output  ROWS  per-row multiply enable, bit i = row i.
REQ-010 busy  output  1  high in LOAD and COMPUTE.
REQ-011 done  output  1  single-cycle completion pulse.

Function
REQ-012 All outputs SHALL be registered; state machine states IDLE, LOAD, COMPUTE, DONE.
REQ-013 IDLE: all outputs 0; start=1 at an edge with enable=1 SHALL move to LOAD with row counter 0.
REQ-014 LOAD: load_weight SHALL equal 1<<row_cnt, one row per enabled cycle, rows 0..ROWS-1 in order, enable_mult 0.
REQ-015 After row ROWS-1 is strobed, FSM SHALL enter COMPUTE with step 0, load_weight 0.
REQ-016 COMPUTE: steps s = 0..ROWS+COLS-2, each lasting exactly STEP_CYCLES enabled cycles.
REQ-017 During step s, enable_mult[i] SHALL be 1 iff i <= s < i+COLS (diagonal wavefront fill and drain).
REQ-018 After last cycle of step ROWS+COLS-2, FSM SHALL enter DONE: done=1, enable_mult=0, busy=0 for one cycle, then IDLE.
REQ-019 Latency from accepted start to done SHALL be ROWS + (ROWS+COLS-1)*STEP_CYCLES + 1 enabled cycles.
REQ-020 start while not IDLE SHALL be ignored; start held high in DONE SHALL not be accepted until IDLE.
REQ-021 enable low in any state SHALL hold state, counters and every output (done pulse stretches while frozen).
REQ-022 Step and row counters SHALL be sized $clog2 of their maximum +1; no wrap-around inside a pass.

Reset
REQ-023 reset SHALL take priority over enable and start, forcing IDLE and all counters to 0.
REQ-024 After reset edge, load_weight, enable_mult, busy, done SHALL all be 0, including reset mid-LOAD or mid-COMPUTE.

Configuration
REQ-025 Macro SCHED_REUSE_WEIGHTS_EN SHALL add input reuse_weights (1 bit), sampled with start.
REQ-026 With the macro defined and reuse_weights=1 at accepted start, FSM SHALL skip LOAD and enter COMPUTE directly (latency reduces by ROWS).
REQ-027 Without the macro the port SHALL not exist and every pass SHALL execute LOAD.

Structure
REQ-028 Package sched_pkg SHALL hold the state enum (IDLE, LOAD, COMPUTE, DONE) and counter-width helper constants.
REQ-029 Sub-module step_timer SHALL count STEP_CYCLES enabled cycles and emit a one-cycle step_tick; it is cleared by reset and by COMPUTE entry.

Verification
REQ-030 ROWS=2,COLS=2,STEP_CYCLES=4, start at edge 0 -> load_weight 01,10 in cycles 1-2; enable_mult 01 (3-6), 11 (7-10), 10 (11-14); done=1 cycle 15.
REQ-031 ROWS=3,COLS=2,STEP_CYCLES=1 -> enable_mult sequence 001,011,110,100; done 8 cycles after start.
REQ-032 Same as REQ-030 with enable low for 3 cycles during step 1 -> enable_mult 11 held 7 cycles, done at cycle 18.
REQ-033 reset asserted in cycle 8 of REQ-030 run -> all outputs 0 next cycle; new start accepted normally afterwards.
REQ-034 start pulsed during COMPUTE and held through DONE -> no second pass until IDLE, then exactly one new pass.
REQ-035 SCHED_REUSE_WEIGHTS_EN defined, reuse_weights=1, REQ-030 parameters -> no load_weight strobes, enable_mult 01 from cycle 1, done at cycle 13.
